// File: rtl/button_event_gen.sv
// Single-clock button conditioner: synchroniser, integrating debouncer and
// press/release/auto-repeat pulse generator feeding a counter enable.
module button_event_gen #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int HOLD_CYCLES     = 50000000,
    parameter int REPEAT_CYCLES   = 10000000,
    parameter int REPEAT_EN       = 1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_btn,
    output logic o_level,
    output logic o_press,
    output logic o_release,
    output logic o_repeat,
    output logic o_event
);

    localparam int DW   = $clog2(DEBOUNCE_CYCLES);
    localparam int HMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int HW   = $clog2(HMAX);

    localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [HW-1:0] REP_LAST  = HW'(REPEAT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        HELD,
        REPEAT
    } state_t;

    logic [SYNC_STAGES-1:0] sync;
    logic                   s_btn;
    logic [DW-1:0]          db_cnt;
    logic                   differ;
    logic                   toggle;
    logic                   rise;
    logic                   fall;

    state_t                 state;
    state_t                 state_n;
    logic [HW-1:0]          hold_cnt;
    logic [HW-1:0]          hold_n;
    logic                   rep_hit;

    assign s_btn  = sync[SYNC_STAGES-1];
    assign differ = (s_btn != o_level);
    assign toggle = differ && (db_cnt == DB_LAST);
    assign rise   = toggle && !o_level;
    assign fall   = toggle && o_level;

    // Synchroniser chain for the asynchronous button pin.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sync <= '0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], i_btn};
        end
    end

    // Integrating debouncer: count consecutive differing samples, toggle level on the last one.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            db_cnt  <= '0;
            o_level <= 1'b0;
        end else begin
            if (!differ || toggle) begin
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + DW'(1);
            end
            o_level <= o_level ^ toggle;
        end
    end

    // Hold/repeat FSM state and counter register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state    <= IDLE;
            hold_cnt <= '0;
        end else begin
            state    <= state_n;
            hold_cnt <= hold_n;
        end
    end

    // Next-state logic; a debounced fall overrides any hold/repeat expiry on the same edge.
    always_comb begin
        state_n = state;
        hold_n  = hold_cnt;
        rep_hit = 1'b0;
        if (fall) begin
            state_n = IDLE;
            hold_n  = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (rise) begin
                        state_n = HELD;
                        hold_n  = '0;
                    end
                end
                HELD: begin
                    if (hold_cnt == HOLD_LAST) begin
                        if (REPEAT_EN != 0) begin
                            rep_hit = 1'b1;
                            state_n = REPEAT;
                            hold_n  = '0;
                        end
                    end else begin
                        hold_n = hold_cnt + HW'(1);
                    end
                end
                REPEAT: begin
                    if (hold_cnt == REP_LAST) begin
                        rep_hit = 1'b1;
                        hold_n  = '0;
                    end else begin
                        hold_n = hold_cnt + HW'(1);
                    end
                end
                default: begin
                    state_n = IDLE;
                    hold_n  = '0;
                end
            endcase
        end
    end

    // Registered one-cycle pulses, aligned with the o_level update.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_press   <= 1'b0;
            o_release <= 1'b0;
            o_repeat  <= 1'b0;
            o_event   <= 1'b0;
        end else begin
            o_press   <= rise;
            o_release <= fall;
            o_repeat  <= rep_hit;
            o_event   <= rise | rep_hit;
        end
    end

endmodule
